// File: rtl/gba_eeprom_pkg.sv
// Shared types and protocol constants for the GBA EEPROM serial master.
package gba_eeprom_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StAddr,
    StRdStop,
    StRdHead,
    StRdData,
    StWrData,
    StWrStop,
    StPoll,
    StFinish
  } frame_state_e;

  typedef enum logic {
    StBitReady,
    StBitGap
  } bit_state_e;

  localparam logic [1:0] CMD_READ  = 2'b11;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam int unsigned ADDR_W_SMALL = 6;
  localparam int unsigned ADDR_W_LARGE = 14;
  localparam int unsigned HEAD_BITS    = 4;
  localparam int unsigned DATA_BITS    = 64;

  // Bit-counter reload value for the address phase (index of the address MSB).
  function automatic logic [6:0] addr_last_bit(input logic model);
    return model ? 7'(ADDR_W_LARGE - 1) : 7'(ADDR_W_SMALL - 1);
  endfunction

endpackage

// File: rtl/gba_eeprom_bitio.sv
// One serial transaction: holds valid until ready, inserts GAP_CYCLES idle cycles,
// and presents ee_dout on bit_rx in the cycle after the handshake (with bit_done).
module gba_eeprom_bitio
  import gba_eeprom_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic tx_write,
  input  logic tx_bit,
  output logic bit_done,
  output logic bit_rx,
  output logic ee_valid,
  output logic ee_write,
  output logic ee_din,
  input  logic ee_ready,
  input  logic ee_dout
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  bit_state_e      state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            done_q;
  logic            handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBitReady;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      done_q  <= handshake;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StBitReady: begin
        if (handshake) begin
          state_d = StBitGap;
          gap_d   = GapW'(GAP_CYCLES - 1);
        end
      end
      StBitGap: begin
        if (gap_q == '0) state_d = StBitReady;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = StBitReady;
    endcase
  end

  // tx_write/tx_bit come from frame registers that only move after bit_done,
  // so they stay stable for the whole valid/ready hold.
  always_comb begin
    ee_valid  = (state_q == StBitReady) && start;
    ee_write  = tx_write;
    ee_din    = tx_bit;
    handshake = ee_valid && ee_ready;
    bit_done  = done_q;
    bit_rx    = ee_dout;
  end

endmodule

// File: rtl/gba_eeprom_master.sv
// GBA cartridge EEPROM initiator: reads or writes one 64-bit block per request.
// Define GBA_EEPROM_MASTER_VERIFY_EN to read back and compare after each write.
module gba_eeprom_master
  import gba_eeprom_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 4096,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        model,
  input  logic        req,
  input  logic        req_write,
  input  logic [13:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] rdata,
  output logic        ee_cs,
  output logic        ee_valid,
  output logic        ee_write,
  output logic        ee_din,
  input  logic        ee_ready,
  input  logic        ee_dout
);

  localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);

  frame_state_e     state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic             op_write_q, model_q, error_q;
  logic [13:0]      addr_q;
  logic [63:0]      wdata_q, shadow_q, rdata_q, shadow_next;
  logic             start, tx_write, tx_bit, bit_done, bit_rx;
  logic             last_bit, poll_expired;
  logic [1:0]       cmd;
`ifdef GBA_EEPROM_MASTER_VERIFY_EN
  logic             verify_q;
`endif

  gba_eeprom_bitio #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_bitio (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tx_write (tx_write),
    .tx_bit   (tx_bit),
    .bit_done (bit_done),
    .bit_rx   (bit_rx),
    .ee_valid (ee_valid),
    .ee_write (ee_write),
    .ee_din   (ee_din),
    .ee_ready (ee_ready),
    .ee_dout  (ee_dout)
  );

  assign last_bit     = bit_done && (cnt_q == '0);
  assign poll_expired = (poll_q == PollW'(POLL_LIMIT - 1));
  assign shadow_next  = {shadow_q[62:0], bit_rx};
  assign error        = error_q;
  assign rdata        = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
    end
  end

  // cnt_q counts down to 0 within each phase and doubles as the MSB-first bit index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    poll_d  = poll_q;
    if (bit_done && cnt_q != '0) cnt_d = cnt_q - 7'd1;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StCmd;
          cnt_d   = 7'd1;
        end
      end
      StCmd: begin
        if (last_bit) begin
          state_d = StAddr;
          cnt_d   = addr_last_bit(model_q);
        end
      end
      StAddr: begin
        if (last_bit) begin
          state_d = op_write_q ? StWrData : StRdStop;
          cnt_d   = op_write_q ? 7'(DATA_BITS - 1) : 7'd0;
        end
      end
      StRdStop: begin
        if (last_bit) begin
          state_d = StRdHead;
          cnt_d   = 7'(HEAD_BITS - 1);
        end
      end
      StRdHead: begin
        if (last_bit) begin
          state_d = StRdData;
          cnt_d   = 7'(DATA_BITS - 1);
        end
      end
      StRdData: if (last_bit) state_d = StFinish;
      StWrData: if (last_bit) state_d = StWrStop;
      StWrStop: begin
        if (last_bit) begin
          state_d = StPoll;
          poll_d  = '0;
        end
      end
      StPoll: begin
        if (bit_done) begin
          if (bit_rx) begin
`ifdef GBA_EEPROM_MASTER_VERIFY_EN
            state_d = StCmd;
            cnt_d   = 7'd1;
`else
            state_d = StFinish;
`endif
          end else if (poll_expired) begin
            state_d = StFinish;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q != StIdle);
    ee_cs    = busy;
    done     = (state_q == StFinish);
    start    = 1'b0;
    tx_write = 1'b0;
    tx_bit   = 1'b0;
    cmd      = op_write_q ? CMD_WRITE : CMD_READ;
    unique case (state_q)
      StCmd: begin
        start    = 1'b1;
        tx_write = 1'b1;
        tx_bit   = cmd[cnt_q[0]];
      end
      StAddr: begin
        start    = 1'b1;
        tx_write = 1'b1;
        tx_bit   = addr_q[cnt_q[3:0]];
      end
      StWrData: begin
        start    = 1'b1;
        tx_write = 1'b1;
        tx_bit   = wdata_q[cnt_q[5:0]];
      end
      StRdStop, StWrStop: begin
        start    = 1'b1;
        tx_write = 1'b1;
      end
      StRdHead, StRdData, StPoll: start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write_q <= 1'b0;
      model_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      shadow_q   <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
`ifdef GBA_EEPROM_MASTER_VERIFY_EN
      verify_q   <= 1'b0;
`endif
    end else begin
      if (state_q == StIdle && req) begin
        op_write_q <= req_write;
        model_q    <= model;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        error_q    <= 1'b0;
`ifdef GBA_EEPROM_MASTER_VERIFY_EN
        verify_q   <= 1'b0;
`endif
      end
      // rdata only changes once the full block has arrived.
      if (bit_done && state_q == StRdData) begin
        shadow_q <= shadow_next;
        if (cnt_q == '0) begin
          rdata_q <= shadow_next;
`ifdef GBA_EEPROM_MASTER_VERIFY_EN
          if (verify_q) error_q <= (shadow_next != wdata_q);
`endif
        end
      end
      if (bit_done && state_q == StPoll) begin
        if (!bit_rx && poll_expired) error_q <= 1'b1;
`ifdef GBA_EEPROM_MASTER_VERIFY_EN
        if (bit_rx) begin
          op_write_q <= 1'b0;
          verify_q   <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_gba_eeprom_master.sv
// Directed bench for gba_eeprom_master against a small behavioural EEPROM responder.
module tb_gba_eeprom_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        model = 1'b0;
  logic        req = 1'b0;
  logic        req_write = 1'b0;
  logic [13:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        busy, done, error, ee_cs, ee_valid, ee_write, ee_din;
  logic [63:0] rdata;
  logic        ee_ready = 1'b1;
  logic        ee_dout = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  gba_eeprom_master #(
    .POLL_LIMIT (16),
    .GAP_CYCLES (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .model     (model),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .rdata     (rdata),
    .ee_cs     (ee_cs),
    .ee_valid  (ee_valid),
    .ee_write  (ee_write),
    .ee_din    (ee_din),
    .ee_ready  (ee_ready),
    .ee_dout   (ee_dout)
  );

  always #5 clk = ~clk;

  // Responder state.
  logic [63:0] mem [int];
  bit          sb [0:127];
  int          ns = 0, nr = 0, polls = 0, wr_sends = 0, aw = 6;
  bit          rd_frame = 0, wr_done = 0, never_ready = 0, corrupt = 0, cur_model = 0;
  logic [1:0]  cmd_r = '0, wr_cmd_snap = '0;
  logic [13:0] last_addr = '0, wr_addr_snap = '0;
  logic [63:0] rd_block = '0, tmp = '0;
  bit          hs = 0, hs_w = 0, hs_d = 0, cs_s = 0;
  bit          stall_en = 0, stall_first = 1;
  int          stall_left = 0, stall_viol = 0;
  logic [1:0]  stall_ref = '0;
  int          polls_snap = 0;

  function automatic logic [63:0] field(input int lo, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], sb[lo+i]};
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive ready and snapshot the bus away from the active edge.
  always @(negedge clk) begin
    if (stall_en && ee_cs && ns == 9 && stall_left > 0) begin
      ee_ready = 1'b0;
      if (ee_valid) begin
        if (stall_first) begin
          stall_ref   = {ee_write, ee_din};
          stall_first = 0;
        end else if ({ee_write, ee_din} != stall_ref) begin
          stall_viol++;
        end
        stall_left--;
      end else if (!stall_first) begin
        stall_viol++;
      end
    end else begin
      ee_ready = 1'b1;
    end
    hs   = ee_valid && ee_ready && ee_cs;
    hs_w = ee_write;
    hs_d = ee_din;
    cs_s = ee_cs;
  end

  always @(posedge clk) begin
    aw = cur_model ? 14 : 6;
    if (!cs_s) begin
      ns = 0; nr = 0; polls = 0; rd_frame = 0; wr_done = 0;
    end else if (hs) begin
      if (hs_w) begin
        if (wr_done) begin
          ns = 0; nr = 0; rd_frame = 0; wr_done = 0;
        end
        sb[ns] = hs_d;
        ns++;
        if (ns == 2) cmd_r = {sb[0], sb[1]};
        if (cmd_r == 2'b11 && ns == 3 + aw) begin
          tmp       = field(2, aw);
          last_addr = tmp[13:0];
          rd_block  = mem.exists(int'(last_addr)) ? mem[int'(last_addr)] : 64'h0;
          rd_frame  = 1;
        end
        if (cmd_r == 2'b10 && ns == 3 + aw + 64) begin
          tmp          = field(2, aw);
          last_addr    = tmp[13:0];
          wr_addr_snap = last_addr;
          wr_cmd_snap  = cmd_r;
          tmp          = field(2 + aw, 64);
          mem[int'(last_addr)] = corrupt ? (tmp ^ 64'h1) : tmp;
          wr_done  = 1;
          wr_sends = ns;
        end
      end else begin
        if (rd_frame) begin
          ee_dout <= (nr < 4) ? 1'b0 : rd_block[63-(nr-4)];
          nr++;
        end else if (wr_done) begin
          polls++;
          ee_dout <= (!never_ready && polls > 3);
        end else begin
          ee_dout <= 1'b0;
        end
      end
    end
  end

  task automatic do_req(input bit wr, input bit mdl, input logic [13:0] a,
                        input logic [63:0] d, output bit err);
    bit seen = 0;
    @(negedge clk);
    cur_model = mdl; model = mdl;
    req = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    err = error;
    polls_snap = polls;
    check_eq("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      @(negedge clk);
      check_eq("done_pulse", 64'({done, busy}), 64'd0);
    end
  endtask

  initial begin
    bit err;
    bit hit;
    repeat (3) @(negedge clk);
    check_eq("rst_ctl", 64'({busy, done, error, ee_cs, ee_valid, ee_write, ee_din}), 64'd0);
    check_eq("rst_rdata", rdata, 64'd0);
    rst_n = 1'b1;

    // 4Kbit write then read back.
    do_req(1, 0, 14'h2A, 64'h0123_4567_89AB_CDEF, err);
    check_eq("m0_wr_err", 64'(err), 64'd0);
    check_eq("m0_wr_sends", 64'(wr_sends), 64'd73);
    check_eq("m0_wr_polls", 64'(polls_snap), 64'd4);
    do_req(0, 0, 14'h2A, 64'h0, err);
    check_eq("m0_rd_err", 64'(err), 64'd0);
    check_eq("m0_rd_data", rdata, 64'h0123_4567_89AB_CDEF);

    // 64Kbit write/read at the top address.
    do_req(1, 1, 14'h3FFF, 64'hFFFF_0000_A5A5_5A5A, err);
    check_eq("m1_wr_err", 64'(err), 64'd0);
    check_eq("m1_wr_sends", 64'(wr_sends), 64'd81);
    check_eq("m1_wr_cmd", 64'(wr_cmd_snap), 64'h2);
    check_eq("m1_wr_addr", 64'(wr_addr_snap), 64'h3FFF);
    do_req(0, 1, 14'h3FFF, 64'h0, err);
    check_eq("m1_rd_data", rdata, 64'hFFFF_0000_A5A5_5A5A);

    // Ready stalled for 5 cycles on the 10th bit.
    stall_en = 1; stall_left = 5; stall_first = 1; stall_viol = 0;
    do_req(1, 0, 14'h05, 64'h5555_AAAA_0F0F_F0F0, err);
    stall_en = 0;
    check_eq("stall_stable", 64'(stall_viol), 64'd0);
    check_eq("stall_taken", 64'(stall_left), 64'd0);
    check_eq("stall_sends", 64'(wr_sends), 64'd73);
    do_req(0, 0, 14'h05, 64'h0, err);
    check_eq("stall_rd_data", rdata, 64'h5555_AAAA_0F0F_F0F0);

    // Reset in the middle of the data phase of a read.
    @(negedge clk);
    cur_model = 0; model = 1'b0; req = 1'b1; req_write = 1'b0; req_addr = 14'h2A;
    @(negedge clk);
    req = 1'b0;
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      if (nr >= 44) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("rst_mid_reach", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ctl", 64'({busy, done, error, ee_cs, ee_valid, ee_write, ee_din}), 64'd0);
    check_eq("rst_mid_rdata", rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_req(0, 0, 14'h2A, 64'h0, err);
    check_eq("rst_rd_err", 64'(err), 64'd0);
    check_eq("rst_rd_data", rdata, 64'h0123_4567_89AB_CDEF);

    // Responder never completes the write.
    never_ready = 1;
    do_req(1, 0, 14'h11, 64'hDEAD_BEEF_0000_1111, err);
    never_ready = 0;
    check_eq("to_polls", 64'(polls_snap), 64'd16);
    check_eq("to_err", 64'(err), 64'd1);

    // Responder stores bit 0 flipped.
    corrupt = 1;
    do_req(1, 0, 14'h12, 64'hCAFE_F00D_1234_5679, err);
    corrupt = 0;
`ifdef GBA_EEPROM_MASTER_VERIFY_EN
    check_eq("vfy_err", 64'(err), 64'd1);
    check_eq("vfy_rdata", rdata, 64'hCAFE_F00D_1234_5678);
`else
    check_eq("nov_err", 64'(err), 64'd0);
    check_eq("nov_rdata", rdata, 64'h0123_4567_89AB_CDEF);
`endif
    do_req(0, 0, 14'h12, 64'h0, err);
    check_eq("corrupt_rd", rdata, 64'hCAFE_F00D_1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
